// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: stall vector
// layout and encodings, FSM states and default widths.
package pipe_ctrl_pkg;

  localparam int DEF_REG_ADDR_W = 5;
  localparam int DEF_CNT_W      = 6;
  localparam int DEF_PERF_W     = 32;

  localparam int STALL_W = 6;

  // Stall vector bit positions: one hold per pipeline register, PC first.
  localparam int STB_PC  = 0;
  localparam int STB_IF  = 1;
  localparam int STB_ID  = 2;
  localparam int STB_EX  = 3;
  localparam int STB_MEM = 4;
  localparam int STB_WB  = 5;

  // Every stall holds everything upstream of the stage that is blocked.
  localparam logic [STALL_W-1:0] StallNone    = 6'b000000;
  localparam logic [STALL_W-1:0] StallLoadUse = 6'b000111;
  localparam logic [STALL_W-1:0] StallMulti   = 6'b001111;
  localparam logic [STALL_W-1:0] StallMem     = 6'b011111;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_MULTI = 1'b1
  } state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard/stall bus between the pipeline stages and pipe_ctrl.
interface pipe_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int PERF_W     = DEF_PERF_W
) ();

  logic                  id_valid_i;
  logic                  id_reg1_read_i;
  logic [REG_ADDR_W-1:0] id_reg1_addr_i;
  logic                  id_reg2_read_i;
  logic [REG_ADDR_W-1:0] id_reg2_addr_i;
  logic                  ex_is_load_i;
  logic                  ex_wreg_i;
  logic [REG_ADDR_W-1:0] ex_wd_i;
  logic                  ex_multi_i;
  logic [CNT_W-1:0]      ex_multi_cycles_i;
  logic                  mem_busy_i;
  logic                  flush_i;
  logic [STALL_W-1:0]    stall_o;
  logic                  flush_o;
  logic                  ex_multi_done_o;
  logic                  busy_o;
  logic [PERF_W-1:0]     stall_cnt_o;

  modport master (
    output id_valid_i, id_reg1_read_i, id_reg1_addr_i, id_reg2_read_i,
           id_reg2_addr_i, ex_is_load_i, ex_wreg_i, ex_wd_i, ex_multi_i,
           ex_multi_cycles_i, mem_busy_i, flush_i,
    input  stall_o, flush_o, ex_multi_done_o, busy_o, stall_cnt_o
  );

  modport slave (
    input  id_valid_i, id_reg1_read_i, id_reg1_addr_i, id_reg2_read_i,
           id_reg2_addr_i, ex_is_load_i, ex_wreg_i, ex_wd_i, ex_multi_i,
           ex_multi_cycles_i, mem_busy_i, flush_i,
    output stall_o, flush_o, ex_multi_done_o, busy_o, stall_cnt_o
  );

endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing and stall controller: load-use detection, multi-cycle
// EX sequencing, MEM back-pressure, flush, and a saturating stall counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int PERF_W     = DEF_PERF_W
) (
  input  logic         clk,
  input  logic         rst,
  pipe_ctrl_if.slave   io_bus
);

  state_e             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [PERF_W-1:0]  r_stall_cnt;

  state_e             w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [STALL_W-1:0] w_stall;
  logic               w_flush;
  logic               w_done;
  logic               w_load_use;
  logic               w_src1_hit;
  logic               w_src2_hit;

  // A load result reaches the forwarding network only from MEM, so a
  // consumer sitting directly behind it in ID must wait one cycle.
  always_comb begin
    w_src1_hit = io_bus.id_reg1_read_i && (io_bus.id_reg1_addr_i == io_bus.ex_wd_i);
    w_src2_hit = io_bus.id_reg2_read_i && (io_bus.id_reg2_addr_i == io_bus.ex_wd_i);
    w_load_use = io_bus.id_valid_i && io_bus.ex_is_load_i && io_bus.ex_wreg_i &&
                 (io_bus.ex_wd_i != '0) && (w_src1_hit || w_src2_hit);
  end

  always_comb begin
    w_stall     = StallNone;
    w_flush     = 1'b0;
    w_done      = 1'b0;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (!rst) begin
      if (io_bus.flush_i) begin
        w_flush     = 1'b1;
        w_state_nxt = S_RUN;
        w_cnt_nxt   = '0;
      end else if (io_bus.mem_busy_i) begin
        // State and counter hold, so a pending done pulse replays later.
        w_stall = StallMem;
      end else if (r_state == S_MULTI) begin
        if (r_cnt > CNT_W'(1)) begin
          w_stall   = StallMulti;
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          w_done      = 1'b1;
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
        end
      end else if (io_bus.ex_multi_i && (io_bus.ex_multi_cycles_i > CNT_W'(1))) begin
        w_stall     = StallMulti;
        w_cnt_nxt   = io_bus.ex_multi_cycles_i - CNT_W'(1);
        w_state_nxt = S_MULTI;
      end else begin
        w_done = io_bus.ex_multi_i;
        if (w_load_use) w_stall = StallLoadUse;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_RUN;
      r_cnt       <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if ((w_stall != StallNone) && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + PERF_W'(1);
    end
  end

  assign io_bus.stall_o         = w_stall;
  assign io_bus.flush_o         = w_flush;
  assign io_bus.ex_multi_done_o = w_done;
  assign io_bus.busy_o          = !rst && (r_state == S_MULTI);
  assign io_bus.stall_cnt_o     = r_stall_cnt;

endmodule
